// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: raster defaults, mode codes, colour codes.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BARS   = 2'd3
  } mode_e;

  // One bit per channel {r,g,b}; a set bit means that channel is full scale.
  typedef logic [2:0] rgb_code_t;

  localparam rgb_code_t RGB_BLACK = 3'b000;
  localparam rgb_code_t RGB_RED   = 3'b100;
  localparam rgb_code_t RGB_WHITE = 3'b111;

  // Expand one channel bit of a colour code to a full-scale or zero channel value.
  function automatic logic [15:0] chan_level(input logic on);
    return on ? 16'hFFFF : 16'h0000;
  endfunction

endpackage

// File: rtl/vga_pattern_bitgen_if.sv
// Pixel-side bundle between the timing controller, the pattern generator and the DAC.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is paced by pix_en.
interface vga_pattern_bitgen_if #(
  parameter int COLOR_W = 8
);
  logic               pix_en;
  logic               bright;
  logic [9:0]         hCount;
  logic [9:0]         vCount;
  logic [1:0]         mode;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  // Timing controller / test side: drives raster position, receives colour.
  modport master (
    output pix_en, bright, hCount, vCount, mode,
    input  red, green, blue
  );

  // Pattern generator side.
  modport slave (
    input  pix_en, bright, hCount, vCount, mode,
    output red, green, blue
  );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position state: moves STEP pixels per axis per enabled frame tick, reflecting at edges.
// Latency: new position visible one clock after the tick.
// Backpressure: none; holds whenever tick or enable is low.
module vga_box_mover #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32,
  parameter int BOX_X0   = 100,
  parameter int BOX_Y0   = 150,
  parameter int STEP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  logic dir_x;
  logic dir_y;
  logic [10:0] nxt_x;
  logic [10:0] nxt_y;

  // One axis step; returns {new_dir, new_pos}. 11-bit arithmetic so the far-edge test cannot wrap.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input int act, input int sz);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir) begin
      if (p + 11'(sz + STEP) > 11'(act)) return {1'b0, 10'(act - sz)};
      else                               return {1'b1, 10'(p + 11'(STEP))};
    end else begin
      if (p < 11'(STEP)) return {1'b1, 10'd0};
      else               return {1'b0, 10'(p - 11'(STEP))};
    end
  endfunction

  // Both axes are evaluated independently so a corner hit flips both directions at once.
  always_comb begin
    nxt_x = step_axis(box_x, dir_x, H_ACTIVE, BOX_W);
    nxt_y = step_axis(box_y, dir_y, V_ACTIVE, BOX_H);
  end

  // Position/direction register; reset wins over any coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      box_x <= 10'(BOX_X0);
      box_y <= 10'(BOX_Y0);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (tick && enable) begin
      box_x <= nxt_x[9:0];
      dir_x <= nxt_x[10];
      box_y <= nxt_y[9:0];
      dir_y <= nxt_y[10];
    end
  end

endmodule

// File: rtl/vga_pattern_bitgen.sv
// Registered VGA pattern generator: solid red, static box, bouncing box or colour bars.
// Latency: colour for a pix_en pixel appears one clock later; outputs hold between pix_en pulses.
// Backpressure: none; consumes one pixel per pix_en cycle.
module vga_pattern_bitgen
  import vga_pkg::*;
#(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32,
  parameter int BOX_X0   = 100,
  parameter int BOX_Y0   = 150,
  parameter int STEP     = 2,
  parameter int BAR_W    = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_pattern_bitgen_if.slave   vif
);

  if (BOX_W + STEP > H_ACTIVE) begin : g_bad_box_w
    $error("BOX_W + STEP must not exceed H_ACTIVE");
  end
  if (BOX_H + STEP > V_ACTIVE) begin : g_bad_box_h
    $error("BOX_H + STEP must not exceed V_ACTIVE");
  end
  if (BAR_W < 1) begin : g_bad_bar_w
    $error("BAR_W must be at least 1");
  end

  logic       tick;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [9:0] bar_full;
  logic [2:0] bar_idx;
  rgb_code_t  code_nxt;
  mode_e      mode;

  assign mode = mode_e'(vif.mode);

  // First pixel of the first blanked line: exactly once per frame.
  assign tick = vif.pix_en && (vif.hCount == 10'd0) && (vif.vCount == 10'(V_ACTIVE));

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_W    (BOX_W),
    .BOX_H    (BOX_H),
    .BOX_X0   (BOX_X0),
    .BOX_Y0   (BOX_Y0),
    .STEP     (STEP)
  ) u_mover (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .enable (mode == MODE_BOUNCE),
    .box_x  (box_x),
    .box_y  (box_y)
  );

  // Half-open box test with 11-bit compares so box_x+BOX_W cannot wrap.
  function automatic logic box_hit(input logic [9:0] h, input logic [9:0] v,
                                   input logic [9:0] bx, input logic [9:0] by);
    logic [10:0] h11, v11, bx11, by11;
    h11  = {1'b0, h};
    v11  = {1'b0, v};
    bx11 = {1'b0, bx};
    by11 = {1'b0, by};
    return (h11 >= bx11) && (h11 < bx11 + 11'(BOX_W)) &&
           (v11 >= by11) && (v11 < by11 + 11'(BOX_H));
  endfunction

  // Bar index, saturated so columns past the eighth bar stay white.
  always_comb begin
    bar_full = vif.hCount / 10'(BAR_W);
    bar_idx  = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
  end

  // Colour selection for the pixel currently presented; blanking overrides every mode.
  always_comb begin
    code_nxt = RGB_BLACK;
    if (vif.bright) begin
      case (mode)
        MODE_SOLID:  code_nxt = RGB_RED;
        MODE_STATIC: code_nxt = box_hit(vif.hCount, vif.vCount, 10'(BOX_X0), 10'(BOX_Y0))
                                ? RGB_WHITE : RGB_RED;
        MODE_BOUNCE: code_nxt = box_hit(vif.hCount, vif.vCount, box_x, box_y)
                                ? RGB_WHITE : RGB_RED;
        MODE_BARS:   code_nxt = bar_idx;
        default:     code_nxt = RGB_BLACK;
      endcase
    end
  end

  // Output register: loads only on pix_en, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vif.red   <= '0;
      vif.green <= '0;
      vif.blue  <= '0;
    end else if (vif.pix_en) begin
      vif.red   <= COLOR_W'(chan_level(code_nxt[2]));
      vif.green <= COLOR_W'(chan_level(code_nxt[1]));
      vif.blue  <= COLOR_W'(chan_level(code_nxt[0]));
    end
  end

endmodule

// File: tb/tb_vga_pattern_bitgen.sv
// Directed bench for vga_pattern_bitgen: modes, blanking, hold, bounce, corner, reset.
// Latency: checks colour one clock after each pix_en pixel.
// Backpressure: n/a.
module tb_vga_pattern_bitgen;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_pattern_bitgen_if #(.COLOR_W(8)) vif ();
  vga_pattern_bitgen_if #(.COLOR_W(8)) vif_c ();

  vga_pattern_bitgen dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  // Second instance whose reset position sits one step short of the far corner.
  vga_pattern_bitgen #(.BOX_X0(607), .BOX_Y0(447)) dut_c (
    .clk   (clk),
    .reset (reset),
    .vif   (vif_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vif.red, vif.green, vif.blue};
  endfunction

  // Present one pixel for a single pix_en cycle; outputs are sampled 1 ns after the loading edge.
  task automatic pix(input logic [1:0] m, input logic b, input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    vif.mode   = m;
    vif.bright = b;
    vif.hCount = h;
    vif.vCount = v;
    vif.pix_en = 1'b1;
    @(posedge clk);
    #1;
    vif.pix_en = 1'b0;
  endtask

  task automatic ticks(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) pix(m, 1'b0, 10'd0, 10'd480);
  endtask

  initial begin
    reset       = 1'b1;
    vif.pix_en  = 1'b0;
    vif.bright  = 1'b0;
    vif.hCount  = '0;
    vif.vCount  = '0;
    vif.mode    = 2'd0;
    vif_c.pix_en = 1'b0;
    vif_c.bright = 1'b0;
    vif_c.hCount = '0;
    vif_c.vCount = '0;
    vif_c.mode   = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", rgb(), 32'h000000);
    chk("reset_x", dut.u_mover.box_x, 100);
    chk("reset_y", dut.u_mover.box_y, 150);
    chk("reset_dirs", {dut.u_mover.dir_x, dut.u_mover.dir_y}, 2'b11);
    @(negedge clk);
    reset = 1'b0;

    // Solid red and blanking.
    pix(2'd0, 1'b1, 10'd0, 10'd0);
    chk("m0_red", rgb(), 32'hFF0000);
    pix(2'd0, 1'b0, 10'd0, 10'd0);
    chk("m0_blank", rgb(), 32'h000000);

    // Output holds while pix_en is low, even with inputs changing.
    pix(2'd0, 1'b1, 10'd5, 10'd5);
    @(negedge clk);
    vif.mode = 2'd3; vif.bright = 1'b1; vif.hCount = 10'd600;
    @(posedge clk);
    #1;
    chk("hold", rgb(), 32'hFF0000);

    // Static box edges.
    pix(2'd1, 1'b1, 10'd100, 10'd150);
    chk("m1_in", rgb(), 32'hFFFFFF);
    pix(2'd1, 1'b1, 10'd132, 10'd150);
    chk("m1_right", rgb(), 32'hFF0000);
    pix(2'd1, 1'b1, 10'd99, 10'd181);
    chk("m1_left", rgb(), 32'hFF0000);

    // Colour bars including saturation at the last bar.
    pix(2'd3, 1'b1, 10'd0, 10'd10);
    chk("bar_0", rgb(), 32'h000000);
    pix(2'd3, 1'b1, 10'd80, 10'd10);
    chk("bar_80", rgb(), 32'h0000FF);
    pix(2'd3, 1'b1, 10'd239, 10'd10);
    chk("bar_239", rgb(), 32'h00FF00);
    pix(2'd3, 1'b1, 10'd560, 10'd10);
    chk("bar_560", rgb(), 32'hFFFFFF);
    pix(2'd3, 1'b1, 10'd639, 10'd10);
    chk("bar_639", rgb(), 32'hFFFFFF);

    // Bouncing box: ten ticks from reset.
    ticks(2'd2, 10);
    chk("b10_x", dut.u_mover.box_x, 120);
    chk("b10_y", dut.u_mover.box_y, 170);
    pix(2'd2, 1'b1, 10'd120, 10'd170);
    chk("b10_hit", rgb(), 32'hFFFFFF);
    pix(2'd2, 1'b1, 10'd119, 10'd170);
    chk("b10_miss", rgb(), 32'hFF0000);

    // Run to the right edge: 254 ticks reach 608 still heading right.
    ticks(2'd2, 244);
    chk("edge_x", dut.u_mover.box_x, 608);
    chk("edge_dir_pre", dut.u_mover.dir_x, 1'b1);
    ticks(2'd2, 1);
    chk("clamp_x", dut.u_mover.box_x, 608);
    chk("clamp_dir", dut.u_mover.dir_x, 1'b0);
    ticks(2'd2, 1);
    chk("back_x", dut.u_mover.box_x, 606);
    chk("back_y", dut.u_mover.box_y, 236);

    // Ticks outside bounce mode leave the box alone.
    ticks(2'd1, 2);
    ticks(2'd3, 1);
    ticks(2'd0, 1);
    chk("frozen_x", dut.u_mover.box_x, 606);
    chk("frozen_y", dut.u_mover.box_y, 236);
    pix(2'd2, 1'b1, 10'd637, 10'd267);
    chk("b_corner_in", rgb(), 32'hFFFFFF);
    pix(2'd2, 1'b1, 10'd638, 10'd236);
    chk("b_right_out", rgb(), 32'hFF0000);
    pix(2'd2, 1'b1, 10'd606, 10'd268);
    chk("b_bottom_out", rgb(), 32'hFF0000);

    // Corner reflection on the second instance.
    @(negedge clk);
    vif_c.hCount = 10'd0; vif_c.vCount = 10'd480; vif_c.pix_en = 1'b1;
    @(posedge clk);
    #1;
    vif_c.pix_en = 1'b0;
    chk("corner_x", dut_c.u_mover.box_x, 608);
    chk("corner_y", dut_c.u_mover.box_y, 448);
    chk("corner_dirs", {dut_c.u_mover.dir_x, dut_c.u_mover.dir_y}, 2'b00);

    // Reset mid-frame in bounce mode, with a coincident tick on the second reset cycle.
    pix(2'd2, 1'b1, 10'd606, 10'd236);
    chk("pre_rst_white", rgb(), 32'hFFFFFF);
    @(negedge clk);
    reset = 1'b1;
    vif.mode = 2'd2; vif.bright = 1'b1; vif.hCount = 10'd606; vif.vCount = 10'd236;
    vif.pix_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rgb", rgb(), 32'h000000);
    @(negedge clk);
    vif.bright = 1'b0; vif.hCount = 10'd0; vif.vCount = 10'd480;
    @(posedge clk);
    #1;
    chk("rst_tick_x", dut.u_mover.box_x, 100);
    chk("rst_tick_y", dut.u_mover.box_y, 150);
    chk("rst_dirs", {dut.u_mover.dir_x, dut.u_mover.dir_y}, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    vif.pix_en = 1'b0;
    vif.bright = 1'b1; vif.hCount = 10'd100; vif.vCount = 10'd150;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_hold", rgb(), 32'h000000);
    pix(2'd2, 1'b1, 10'd100, 10'd150);
    chk("post_rst_hit", rgb(), 32'hFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_pattern_bitgen.md
# vga_pattern_bitgen

Parametrised, registered successor to the combinational VGA pixel colour generator. It sits between the VGA timing controller, which supplies `bright`, `hCount`, `vCount` and `pix_en`, and the DAC/output pins. It provides four run-time modes: solid background, static box, bouncing box and colour bars. Each output colour channel is `COLOR_W` bits wide. The bouncing box is advanced once per frame by an internal position state machine.

## Interface
- `COLOR_W`, 8, bits per colour channel
- `H_ACTIVE`, 640, visible pixels per line
- `V_ACTIVE`, 480, visible lines per frame
- `BOX_W`, 32, box width in pixels
- `BOX_H`, 32, box height in pixels
- `BOX_X0`, 100, box reset x (left edge)
- `BOX_Y0`, 150, box reset y (top edge)
- `STEP`, 2, pixels moved per frame on each axis
- `BAR_W`, 80, colour-bar width in pixels
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-rate enable; all state advances only when it is high
- `bright`  in  1  high inside the visible region
- `hCount`  in  10  current pixel column
- `vCount`  in  10  current line
- `mode`  in  2  0 = solid red, 1 = static white box on red, 2 = bouncing white box on red, 3 = colour bars
- `red`  out  COLOR_W  registered red
- `green`  out  COLOR_W  registered green
- `blue`  out  COLOR_W  registered blue

## Operation
- Colour constants are full-scale (`MAX` = all ones) or 0:
  - RED = {MAX,0,0}
  - WHITE = {MAX,MAX,MAX}
  - BLACK = {0,0,0}
- Blanking: when `bright` = 0, the next registered output is BLACK, regardless of mode.
- Box hit test: true when `box_x ≤ hCount < box_x+BOX_W` and `box_y ≤ vCount < box_y+BOX_H`. Use 11-bit unsigned compares so there is no wrap.
- Mode 0: RED.
- Mode 1: box at (`BOX_X0`, `BOX_Y0`). WHITE on a hit, otherwise RED.
- Mode 2: box at the live `box_x`/`box_y`. WHITE on a hit, otherwise RED.
- Mode 3: bar index `idx` = `hCount/BAR_W`, saturated at 7. Output = {`idx[2]`?MAX:0, `idx[1]`?MAX:0, `idx[0]`?MAX:0}. Bar 0 is black and bar 7 is white.
- Frame tick: `tick` = `pix_en` && `hCount`==0 && `vCount`==`V_ACTIVE`. This is exactly one cycle per frame, at the first blanked line.
- Mover state: `box_x`, `box_y` (10b); `dir_x`, `dir_y` (1 = +, 0 = −). It updates only when `tick` is high and `mode`==2; otherwise it holds.
- Per-axis update, shown for x (y is identical using `V_ACTIVE` and `BOX_H`):
  - `dir_x`=1 and `box_x+BOX_W+STEP` > `H_ACTIVE`: set `box_x`=`H_ACTIVE−BOX_W` and `dir_x`=0.
  - `dir_x`=1 otherwise: `box_x` += `STEP`.
  - `dir_x`=0 and `box_x` < `STEP`: set `box_x`=0 and `dir_x`=1.
  - `dir_x`=0 otherwise: `box_x` −= `STEP`.
  - Both axes evaluate independently in the same cycle. A corner hit flips both directions.
- A `mode` change takes effect on the next `pix_en` pixel. The box position persists across mode changes; it is not re-centred.
- Reset:
  - `red`/`green`/`blue` = 0.
  - `box_x`=`BOX_X0`, `box_y`=`BOX_Y0`, `dir_x`=`dir_y`=1.
- Reset mid-frame takes effect on the next clock. Output is BLACK until the first `pix_en` after `reset` deasserts.

## Timing
- Latency: RGB for pixel (`hCount`, `vCount`) presented with `pix_en` appears on the outputs at the next rising `clk`, which is 1 clock after that `pix_en` cycle. Outputs hold between `pix_en` pulses.
- Box movement is visible from the first visible line after `tick`, so there is no tearing within a frame.
- `reset` has priority over `pix_en` and `tick`.
- All logic runs on one clock edge; there are no combinational outputs.
- Parameter legality, checked at elaboration:
  - `BOX_W+STEP ≤ H_ACTIVE`
  - `BOX_H+STEP ≤ V_ACTIVE`
  - `BAR_W ≥ 1`

## Structure
- Shared package `vga_pkg`:
  - `H_ACTIVE`/`V_ACTIVE` defaults
  - mode encodings `MODE_SOLID`/`MODE_STATIC`/`MODE_BOUNCE`/`MODE_BARS`
  - colour-constant helper for `COLOR_W`
- Sub-module `vga_box_mover`:
  - owns `box_x`/`box_y`/`dir` and the reflection logic
  - inputs: `clk`, `reset`, `tick`, `enable`
  - outputs: `box_x`, `box_y`
- The top level holds the tick detect, hit test, bar decode and output register.

## Test plan
- Mode 0, `bright`=1 at (0,0) → `red`=0xFF, `green`=`blue`=0x00 one clock after `pix_en`. With `bright`=0 → all 0.
- Mode 1 at (100,150) → WHITE; at (132,150) → RED; at (99,181) → RED.
- Mode 3 at `hCount` 0, 80, 239, 560, 639 → BLACK, {0,0,FF}, {0,FF,0}, WHITE, WHITE.
- Mode 2, from reset, 10 `tick`s → box at (120,170). Drive frames until the x-edge: `box_x` clamps to 608, `dir_x`=0, and the next tick gives 606.
- Corner: force the box to (607,447) with `dir` = (+,+), `STEP`=2, tick → (608,448) with both directions negative. Ticks while mode ≠ 2 → position unchanged.
- Assert `reset` mid-frame during mode 2 → outputs 0 next clock, box at (100,150), dirs +. `tick` coincident with `reset` is ignored.
